// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch/decode/execute strobes for the load/store/ALU subset.
// Optional macro MEM_WAIT_EN: Read/Write steps stall until mem_ready; otherwise every step is one cycle.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic [3:0]  alu_op,
  output logic        run
);

  typedef enum logic [3:0] {
    T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3,
    T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7,
    HALT = 4'd8
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t      state_q;
  logic [4:0]  opcode;
  logic        is_r, is_i, is_ldi, is_ld, is_st, is_halt, uses_alu;
  logic [3:0]  alu_sel;
  logic        mem_ok;
  logic        unused_ir;

  assign opcode    = ir[31:27];
  assign unused_ir = ^ir[26:0];

`ifdef MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign mem_ok           = 1'b1;
  assign unused_mem_ready = mem_ready;
`endif

  // Unlisted opcodes fall through every class and therefore execute as nop.
  assign is_r     = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND) || (opcode == OP_OR);
  assign is_i     = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
  assign is_ldi   = (opcode == OP_LDI);
  assign is_ld    = (opcode == OP_LD);
  assign is_st    = (opcode == OP_ST);
  assign is_halt  = (opcode == OP_HALT);
  assign uses_alu = is_r || is_i || is_ldi || is_ld || is_st;

  always_comb begin
    case (opcode)
      OP_SUB:          alu_sel = 4'b0001;
      OP_AND, OP_ANDI: alu_sel = 4'b0010;
      OP_OR,  OP_ORI:  alu_sel = 4'b0011;
      default:         alu_sel = 4'b0000;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= T0;
    end else begin
      case (state_q)
        T0: state_q <= T1;
        T1: if (mem_ok) state_q <= T2;
        T2: state_q <= T3;
        T3: state_q <= uses_alu ? T4 : (is_halt ? HALT : T0);
        T4: state_q <= T5;
        T5: state_q <= (is_ld || is_st) ? T6 : T0;
        T6: begin
          if (is_st) state_q <= T7;
          else if (is_ld) begin
            if (mem_ok) state_q <= T7;
          end else state_q <= T0;
        end
        T7:   if (!is_st || mem_ok) state_q <= T0;
        HALT: state_q <= HALT;
        default: state_q <= T0;
      endcase
    end
  end

  always_comb begin
    {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC} = '0;
    {MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout} = '0;
    alu_op = 4'b0000;
    run    = 1'b0;
    if (!clear) begin
      run = (state_q != HALT);
      case (state_q)
        T0: {PCout, MARin, IncPC, Zin} = 4'b1111;
        T1: {Zlowout, PCin, Read, MDRin} = 4'b1111;
        T2: {MDRout, IRin} = 2'b11;
        T3: begin
          if (is_r || is_i) {Grb, Rout, Yin} = 3'b111;
          else if (uses_alu) {Grb, BAout, Yin} = 3'b111;
        end
        T4: begin
          if (is_r) begin
            {Grc, Rout, Zin} = 3'b111;
            alu_op = alu_sel;
          end else if (is_i) begin
            {Cout, Zin} = 2'b11;
            alu_op = alu_sel;
          end else if (uses_alu) begin
            {Cout, Zin} = 2'b11;
          end
        end
        T5: begin
          if (is_ld || is_st) {Zlowout, MARin} = 2'b11;
          else if (uses_alu) {Zlowout, Gra, Rin} = 3'b111;
        end
        T6: begin
          if (is_ld) {Read, MDRin} = 2'b11;
          else if (is_st) {Gra, Rout, MDRin} = 3'b111;
        end
        T7: begin
          if (is_ld) {MDRout, Gra, Rin} = 3'b111;
          else if (is_st) Write = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction step lists as the reference, directed cases then random traffic.
module tb_control_sequencer;

  logic        clock;
  logic        clear;
  logic [31:0] ir;
  logic        mem_ready;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC;
  logic MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout, run;
  logic [3:0] alu_op;

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Cout(Cout), .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .alu_op(alu_op), .run(run)
  );

`ifdef MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  localparam logic [23:0] RUN     = 24'h000001;
  localparam logic [23:0] A_SUB   = 24'h000002;
  localparam logic [23:0] A_AND   = 24'h000004;
  localparam logic [23:0] A_OR    = 24'h000006;
  localparam logic [23:0] ZLOWOUT = 24'h000020;
  localparam logic [23:0] ZIN     = 24'h000040;
  localparam logic [23:0] YIN     = 24'h000080;
  localparam logic [23:0] IRIN    = 24'h000100;
  localparam logic [23:0] WRITE   = 24'h000200;
  localparam logic [23:0] READ    = 24'h000400;
  localparam logic [23:0] MDROUT  = 24'h000800;
  localparam logic [23:0] MDRIN   = 24'h001000;
  localparam logic [23:0] MARIN   = 24'h002000;
  localparam logic [23:0] INCPC   = 24'h004000;
  localparam logic [23:0] PCIN    = 24'h008000;
  localparam logic [23:0] PCOUT   = 24'h010000;
  localparam logic [23:0] COUT    = 24'h020000;
  localparam logic [23:0] BAOUT   = 24'h040000;
  localparam logic [23:0] ROUT    = 24'h080000;
  localparam logic [23:0] RIN     = 24'h100000;
  localparam logic [23:0] GRC     = 24'h200000;
  localparam logic [23:0] GRB     = 24'h400000;
  localparam logic [23:0] GRA     = 24'h800000;
  localparam logic [23:0] V_T0    = PCOUT | MARIN | INCPC | ZIN | RUN;

  localparam logic [31:0] ADD_IR  = 32'h1A918000;
  localparam logic [31:0] ADDI_IR = 32'h61A7FFFB;
  localparam logic [31:0] LD_IR   = 32'h00900010;
  localparam logic [31:0] ST_IR   = 32'h10800020;
  localparam logic [31:0] HALT_IR = 32'hD8000000;

  logic [23:0] dut_vec;
  assign dut_vec = {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC,
                    MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout, alu_op, run};

  int checks = 0;
  int errors = 0;
  int m_idx = 0;
  bit m_halt = 1'b0;
  bit model_on = 1'b0;
  logic [23:0] obs [0:63];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Whole-instruction step list: bit 24 marks a step that waits on memory.
  function automatic logic [24:0] step_at(input logic [4:0] op, input int idx, output int cnt);
    logic [24:0] q[$];
    logic [23:0] alu;
    case (op)
      5'b00100:           alu = A_SUB;
      5'b00101, 5'b01101: alu = A_AND;
      5'b00110, 5'b01110: alu = A_OR;
      default:            alu = 24'h0;
    endcase
    q.push_back({1'b0, PCOUT | MARIN | INCPC | ZIN | RUN});
    q.push_back({1'b1, ZLOWOUT | PCIN | READ | MDRIN | RUN});
    q.push_back({1'b0, MDROUT | IRIN | RUN});
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        q.push_back({1'b0, GRB | ROUT | YIN | RUN});
        q.push_back({1'b0, GRC | ROUT | ZIN | alu | RUN});
        q.push_back({1'b0, ZLOWOUT | GRA | RIN | RUN});
      end
      5'b01100, 5'b01101, 5'b01110: begin
        q.push_back({1'b0, GRB | ROUT | YIN | RUN});
        q.push_back({1'b0, COUT | ZIN | alu | RUN});
        q.push_back({1'b0, ZLOWOUT | GRA | RIN | RUN});
      end
      5'b00001: begin
        q.push_back({1'b0, GRB | BAOUT | YIN | RUN});
        q.push_back({1'b0, COUT | ZIN | RUN});
        q.push_back({1'b0, ZLOWOUT | GRA | RIN | RUN});
      end
      5'b00000: begin
        q.push_back({1'b0, GRB | BAOUT | YIN | RUN});
        q.push_back({1'b0, COUT | ZIN | RUN});
        q.push_back({1'b0, ZLOWOUT | MARIN | RUN});
        q.push_back({1'b1, READ | MDRIN | RUN});
        q.push_back({1'b0, MDROUT | GRA | RIN | RUN});
      end
      5'b00010: begin
        q.push_back({1'b0, GRB | BAOUT | YIN | RUN});
        q.push_back({1'b0, COUT | ZIN | RUN});
        q.push_back({1'b0, ZLOWOUT | MARIN | RUN});
        q.push_back({1'b0, GRA | ROUT | MDRIN | RUN});
        q.push_back({1'b1, WRITE | RUN});
      end
      default: q.push_back({1'b0, RUN});
    endcase
    cnt = q.size();
    if (idx < cnt) return q[idx];
    return 25'h0;
  endfunction

  // Reference model: advance one step per cycle unless stalled on memory.
  initial begin
    logic [24:0] s;
    int cnt;
    forever begin
      @(posedge clock);
      s = step_at(ir[31:27], m_idx, cnt);
      if (clear) begin
        m_idx = 0;
        m_halt = 1'b0;
        model_on = 1'b1;
      end else if (model_on && !m_halt && !(WAIT_EN && s[24] && !mem_ready)) begin
        if (m_idx + 1 >= cnt) begin
          m_idx = 0;
          m_halt = (ir[31:27] == 5'b11011);
        end else begin
          m_idx = m_idx + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    logic [24:0] s;
    logic [23:0] exp_v;
    int cnt;
    forever begin
      @(negedge clock);
      if (model_on) begin
        s = step_at(ir[31:27], m_idx, cnt);
        exp_v = (clear || m_halt) ? 24'h0 : s[23:0];
        checks++;
        if (dut_vec !== exp_v) begin
          errors++;
          $display("FAIL cycle_cmp t=%0t op=%b step=%0d got=%h exp=%h", $time, ir[31:27], m_idx, dut_vec, exp_v);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic c, input logic [31:0] i, input logic m);
    @(posedge clock);
    #1;
    clear = c;
    ir = i;
    mem_ready = m;
    @(negedge clock);
  endtask

  // Called at the sampling point of a T0 cycle; records until the next T0 or HALT.
  task automatic exec(input logic [31:0] i, input int waits, output int n);
    int waited;
    int cnt;
    bit done;
    logic [24:0] s;
    waited = 0;
    done = 1'b0;
    obs[0] = dut_vec;
    n = 1;
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clock);
      #1;
      clear = 1'b0;
      ir = i;
      s = step_at(i[31:27], m_idx, cnt);
      if (s[24] && m_idx >= 3 && waited < waits) begin
        mem_ready = 1'b0;
        waited++;
      end else begin
        mem_ready = 1'b1;
      end
      @(negedge clock);
      obs[n] = dut_vec;
      n++;
      if (m_idx == 0 || m_halt) done = 1'b1;
    end
    if (!done) chk("exec_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] rand_ir();
    logic [4:0] pool [0:11];
    logic [4:0] op;
    pool = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
             5'b00110, 5'b01100, 5'b01101, 5'b01110, 5'b11010, 5'b11011};
    if ($urandom_range(0, 4) == 0) op = 5'($urandom);
    else op = pool[$urandom_range(0, 11)];
    return {op, 27'($urandom)};
  endfunction

  initial begin
    int n;
    int wcnt;
    bit done;
    clear = 1'b1;
    ir = $urandom;
    mem_ready = 1'b1;

    drive(1'b1, $urandom, 1'($urandom_range(0, 1)));
    chk("reset_quiet0", 32'(dut_vec), 32'h0);
    drive(1'b1, $urandom, 1'($urandom_range(0, 1)));
    chk("reset_quiet1", 32'(dut_vec), 32'h0);
    drive(1'b0, ADD_IR, 1'b1);
    chk("t0_after_reset", 32'(dut_vec), 32'(V_T0));

    exec(ADD_IR, 0, n);
    $display("add: %0d cycles to next T0", n - 1);
    chk("add_t3", 32'(obs[3]), 32'(GRB | ROUT | YIN | RUN));
    chk("add_t4", 32'(obs[4]), 32'(GRC | ROUT | ZIN | RUN));
    chk("add_t5", 32'(obs[5]), 32'(GRA | RIN | ZLOWOUT | RUN));
    chk("add_cycle7_t0", 32'(obs[6]), 32'(V_T0));
    chk("add_len", 32'(n), 32'd7);

    exec(ADDI_IR, 0, n);
    $display("addi: %0d cycles to next T0", n - 1);
    chk("addi_t4", 32'(obs[4]), 32'(COUT | ZIN | RUN));
    chk("addi_len", 32'(n), 32'd7);

    exec(LD_IR, 3, n);
    $display("ld: %0d cycles to next T0", n - 1);
    chk("ld_t5", 32'(obs[5]), 32'(ZLOWOUT | MARIN | RUN));
`ifdef MEM_WAIT_EN
    for (int k = 6; k <= 9; k++) chk("ld_t6_hold", 32'(obs[k]), 32'(READ | MDRIN | RUN));
    chk("ld_t7", 32'(obs[10]), 32'(MDROUT | GRA | RIN | RUN));
    chk("ld_len", 32'(n), 32'd12);
`else
    chk("ld_t6", 32'(obs[6]), 32'(READ | MDRIN | RUN));
    chk("ld_t7", 32'(obs[7]), 32'(MDROUT | GRA | RIN | RUN));
    chk("ld_len", 32'(n), 32'd9);
`endif

    // st with memory never ready in T7
    wcnt = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clock);
      #1;
      clear = 1'b0;
      ir = ST_IR;
      mem_ready = (m_idx == 7) ? 1'b0 : 1'b1;
      @(negedge clock);
      if (Write) wcnt++;
      if (WAIT_EN && wcnt == 2) done = 1'b1;
      if (!WAIT_EN && c > 0 && m_idx == 0) done = 1'b1;
    end
    $display("st: %0d Write cycles observed", wcnt);
    if (!done) chk("st_timeout", 32'd0, 32'd1);
`ifdef MEM_WAIT_EN
    drive(1'b1, ST_IR, 1'b0);
    chk("st_clear_write_drop", 32'(dut_vec), 32'h0);
    drive(1'b0, ST_IR, 1'b0);
    chk("st_clear_t0", 32'(dut_vec), 32'(V_T0));
`else
    chk("st_t7_single", 32'(wcnt), 32'd1);
    chk("st_next_t0", 32'(dut_vec), 32'(V_T0));
`endif

    exec(HALT_IR, 0, n);
    $display("halt: entered after %0d cycles", n - 1);
    chk("halt_len", 32'(n), 32'd5);
    chk("halt_enter", 32'(obs[4]), 32'h0);
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, HALT_IR, 1'($urandom_range(0, 1)));
      chk("halt_idle", 32'(dut_vec), 32'h0);
    end
    drive(1'b1, HALT_IR, 1'b1);
    chk("halt_clear_quiet", 32'(dut_vec), 32'h0);
    drive(1'b0, HALT_IR, 1'b1);
    chk("halt_exit_t0", 32'(dut_vec), 32'(V_T0));

    for (int c = 0; c < 4000; c++) begin
      @(posedge clock);
      #1;
      if (m_idx == 0 && !m_halt) ir = rand_ir();
      mem_ready = ($urandom_range(0, 2) != 0);
      clear = ($urandom_range(0, 49) == 0) || (m_halt && $urandom_range(0, 3) == 0);
      @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Moore-style control FSM that drives the datapath strobes for a load/store/ALU subset of the ISA. It issues the register-select strobes (Gra/Grb/Grc, Rin, Rout, BAout) consumed by the register select/encode logic, along with PC, MAR, MDR, IR, Y and Z strobes and the ALU opcode. It sits between the IR and the bus datapath and performs fetch, decode and execute step by step. Memory accesses use a ready handshake.

## Interface
- No parameters; the opcode map and step encodings below are fixed.
- clock  in  1  sole clock; all state updates on the rising edge.
- clear  in  1  synchronous, active-high reset.
- ir  in  32  IR contents; opcode = ir[31:27].
- mem_ready  in  1  memory completion for the current Read/Write.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register select/direction strobes.
- Cout, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout  out  1 each  datapath strobes.
- alu_op  out  4  ALU function: ADD=0000, SUB=0001, AND=0010, OR=0011; 0000 when unused.
- run  out  1  high while executing; low in HALT and while clear is high.

## Operation
- States: T0–T7 and HALT, held in a 4-bit state register.
- Outputs decode combinationally from the state and ir[31:27]. All strobes and run are forced to 0 while clear=1.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin (memory wait).
  - T2: MDRout, IRin.
- Opcode map:
  - ld=00000, ldi=00001, st=00010
  - add=00011, sub=00100, and=00101, or=00110
  - addi=01100, andi=01101, ori=01110
  - nop=11010, halt=11011
  - Any other opcode executes as nop.
- R-format (add/sub/and/or):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, alu_op, Zin.
  - T5: Zlowout, Gra, Rin → T0.
- I-format (addi/andi/ori):
  - T3: Grb, Rout, Yin.
  - T4: Cout, alu_op, Zin.
  - T5: Zlowout, Gra, Rin → T0.
- ldi: T3 Grb, BAout, Yin; T4 Cout, ADD, Zin; T5 Zlowout, Gra, Rin → T0.
- ld:
  - T3–T4 as ldi.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin (memory wait).
  - T7: MDRout, Gra, Rin → T0.
- st:
  - T3–T4 as ldi.
  - T5: Zlowout, MARin.
  - T6: Gra, Rout, MDRin (Read=0).
  - T7: Write (memory wait) → T0.
- nop: T3 asserts no strobes → T0.
- halt: T3 asserts no strobes → HALT. HALT asserts no strobes and run=0, and is left only via clear.
- Exactly one of Gra/Grb/Grc is asserted in any step that asserts Rin, Rout or BAout. Rin and Rout are never asserted together.
- Sign extension of C is performed downstream; this block only asserts Cout.

## Timing
- clear=1 at a rising edge → state=T0 on the next cycle. This holds from any state, including mid-instruction and during a memory wait.
  - Register writes already completed are not undone.
  - No further strobes from the aborted instruction are issued.
- Memory-wait steps (T1 fetch, ld T6, st T7): strobes hold for as long as the state holds. The state advances on the edge where mem_ready=1.
- mem_ready is ignored in every other state.
- mem_ready already high on entry to a wait step → one-cycle step.
- Zero-wait latency:
  - R-format, I-format, ldi: 6 cycles.
  - ld, st: 8 cycles.
  - nop: 4 cycles.
- Each memory wait cycle adds one cycle.

## Configuration
- MEM_WAIT_EN defined: memory-wait steps honour mem_ready as above.
- MEM_WAIT_EN undefined: every step lasts exactly one cycle and mem_ready is unused (single-cycle memory).

## Test plan
- Reset: hold clear 2 cycles with random ir → all strobes 0 and run=0 during clear. First cycle after release: T0 strobes (PCout, MARin, IncPC, Zin) and run=1.
- add R5,R2,R3 (ir=0x1A918000), mem_ready=1:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, alu_op=0000, Zin.
  - T5: Gra, Rin, Zlowout.
  - Back to T0 on cycle 7.
- addi R3,R4,-5 (ir=0x61A7FFFB) → T4 asserts Cout, alu_op=0000, Zin, with Grc=0.
- ld R1,0x10(R2) (ir=0x00900010), mem_ready low for 3 cycles in T6:
  - T6 Read/MDRin hold for 4 cycles.
  - T7: MDRout, Gra, Rin.
  - Total 11 cycles.
- halt (ir=0xD8000000):
  - Enters HALT after T3; run=0 and all strobes 0 for 20 cycles.
  - clear → T0.
- st with clear asserted during the T7 wait → Write drops the cycle after the clear edge and the state is T0; repeat without MEM_WAIT_EN → T7 lasts exactly 1 cycle.
